// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx transmitter between N byte requesters. In IDLE it picks
// a requester (a locked previous owner first, otherwise round-robin from the
// last owner), latches that requester's byte onto tx_data, and pulses
// tx_start together with a one-hot ack. It then follows tx_busy through the
// whole frame before it arbitrates again. If the transmitter never goes busy
// within START_TIMEOUT cycles, the frame is abandoned and start_err pulses.
//
// Ports
//   clk        : the only clock
//   rst        : asynchronous, active-low reset
//   ena        : allows a new grant in IDLE; frames in flight always finish
//   req[N]     : requester i has a valid byte
//   lock[N]    : requester i keeps ownership for its next byte
//   data[N*8]  : packed bytes, requester i on bits [8i+7:8i]
//   ack[N]     : one-hot, one-cycle "byte taken" pulse
//   tx_data[8] : registered byte to the transmitter
//   tx_start   : one-cycle start pulse to the transmitter
//   tx_busy    : transmitter busy flag
//   active     : high from grant until the frame completes
//   owner      : index of the current or last granted requester
//   start_err  : one-cycle pulse when the transmitter failed to go busy
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N             = 4,
  parameter int IDX_BITS      = $clog2(N),
  parameter int START_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        lock,
  input  logic [N*8-1:0]      data,
  output logic [N-1:0]        ack,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic                active,
  output logic [IDX_BITS-1:0] owner,
  output logic                start_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  localparam logic [IDX_BITS:0]   NUM_REQ      = (IDX_BITS + 1)'(N);
  localparam logic [IDX_BITS-1:0] LAST_RESET   = IDX_BITS'(N - 1);
  localparam logic [3:0]          TIMEOUT_LAST = 4'(START_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [N-1:0]        ack_q, ack_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                active_q, active_d;
  logic [IDX_BITS-1:0] owner_q, owner_d;
  logic                start_err_q, start_err_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_BITS-1:0] last_q, last_d;

  logic [IDX_BITS-1:0] selIdx;
  logic                selValid;
  logic [IDX_BITS:0]   cand;
  logic [IDX_BITS-1:0] candIdx;

  // Requester selection. A locked previous owner that is still requesting
  // wins outright; otherwise scan upward from last+1 (wrapping mod N) and take
  // the first request. The scan ends on last itself, so a lone unlocked
  // requester is still served. A lock bit without req is ignored.
  always_comb begin
    selIdx   = last_q;
    selValid = 1'b0;
    cand     = '0;
    candIdx  = '0;
    if (lock[last_q] && req[last_q]) begin
      selValid = 1'b1;
    end else begin
      for (int i = 1; i <= N; i++) begin
        cand = {1'b0, last_q} + (IDX_BITS + 1)'(i);
        if (cand >= NUM_REQ) begin
          cand = cand - NUM_REQ;
        end
        candIdx = cand[IDX_BITS-1:0];
        if (!selValid && req[candIdx]) begin
          selIdx   = candIdx;
          selValid = 1'b1;
        end
      end
    end
  end

  // Next-state and output logic. Pulses (ack, tx_start, start_err) default
  // low so they last exactly one cycle. last is only advanced once the
  // transmitter has actually gone busy, so an aborted grant does not move
  // the round-robin pointer.
  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    active_d    = active_q;
    owner_d     = owner_q;
    start_err_d = 1'b0;
    cnt_d       = cnt_q;
    last_d      = last_q;

    unique case (state_q)
      IDLE: begin
        if (ena && selValid && !tx_busy) begin
          owner_d        = selIdx;
          tx_data_d      = data[{selIdx, 3'b000} +: 8];
          tx_start_d     = 1'b1;
          ack_d[selIdx]  = 1'b1;
          active_d       = 1'b1;
          cnt_d          = '0;
          state_d        = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          last_d  = owner_q;
          state_d = WAIT_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          start_err_d = 1'b1;
          active_d    = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset puts last at N-1 so that requester 0
  // has first priority after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      active_q    <= 1'b0;
      owner_q     <= '0;
      start_err_q <= 1'b0;
      cnt_q       <= '0;
      last_q      <= LAST_RESET;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      active_q    <= active_d;
      owner_q     <= owner_d;
      start_err_q <= start_err_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  assign ack       = ack_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign active    = active_q;
  assign owner     = owner_q;
  assign start_err = start_err_q;

endmodule
